// File: rtl/result_packer.sv
// result_packer: packs W-bit elements into DW-bit beats (N = DW/W lanes),
// little-endian by lane, with flush-driven tile closing.
//
// Parameters:
//   W   element width (bits)
//   DW  beat width (bits), integer multiple of W with DW/W >= 2
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_data     upstream element stream; in_ready back-pressure
//   flush                single-cycle pulse closing the current tile
//   m_valid/m_data/      downstream beat; m_keep is the per-lane valid mask,
//   m_keep/m_last        m_last marks the final beat of a tile
//   m_ready              downstream accept
//   tile_done            pulses the cycle after an m_last beat handshakes
//   beat_count           beats handshaken since reset (16-bit, wrapping)
//
// Configuration macro: RESULT_PACKER_STATS_EN enables the beat_count
// counter; when undefined beat_count is tied to zero.
module result_packer #(
  parameter int W  = 8,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  output logic            in_ready,
  input  logic            flush,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  output logic [DW/W-1:0] m_keep,
  output logic            m_last,
  input  logic            m_ready,
  output logic            tile_done,
  output logic [15:0]     beat_count
);

  localparam int N  = DW / W;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  if (((DW % W) != 0) || ((DW / W) < 2)) begin : g_bad_cfg
    $fatal(1, "result_packer: DW must be a multiple of W with DW/W >= 2");
  end

  typedef enum logic {S_ACC, S_FLUSH} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [(N-1)*W-1:0]   acc;

  logic                 out_free;
  logic                 accept;
  logic                 full;
  logic                 flush_req;
  logic                 svc_flush;
  logic                 load;
  int unsigned          fill;
  logic [DW-1:0]        lanes;
  logic [DW-1:0]        beat_data;
  logic [N-1:0]         beat_keep;

  assign out_free  = !m_valid || m_ready;
  assign in_ready  = (state == S_ACC) && ((cnt < CNT_MAX) || out_free);
  assign accept    = in_valid && in_ready;
  // The last lane is never stored: it goes straight into the output register.
  assign full      = accept && (cnt == CNT_MAX);
  // A pulse arriving in S_FLUSH adds nothing; the pending request already holds.
  assign flush_req = (state == S_FLUSH) || flush;
  assign svc_flush = flush_req && out_free;
  assign load      = full || svc_flush;

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (flush && !out_free) state_nxt = S_FLUSH;
      S_FLUSH: if (out_free)           state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // One beat builder covers full beats, partial flush beats and empty flush
  // beats: keep/data are derived from the lane fill after this cycle's accept.
  always_comb begin
    lanes     = {{W{1'b0}}, acc};
    fill      = 32'(cnt) + 32'(accept);
    beat_data = '0;
    beat_keep = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (accept && (cnt == CW'(k))) lanes[k*W +: W] = in_data;
      if (k < fill) begin
        beat_keep[k]        = 1'b1;
        beat_data[k*W +: W] = lanes[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      cnt       <= '0;
      acc       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_last    <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      tile_done <= m_valid && m_ready && m_last;

      if (load) begin
        cnt <= '0;
        acc <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
        for (int unsigned k = 0; k < N - 1; k++) begin
          if (cnt == CW'(k)) acc[k*W +: W] <= in_data;
        end
      end

      if (load) begin
        m_valid <= 1'b1;
        m_data  <= beat_data;
        m_keep  <= beat_keep;
        m_last  <= svc_flush;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef RESULT_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                     beat_count <= '0;
    else if (m_valid && m_ready) beat_count <= beat_count + 16'd1;
  end
`else
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_result_packer.sv
module tb_result_packer;

  localparam int W  = 8;
  localparam int DW = 32;
  localparam int N  = DW / W;

`ifdef RESULT_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_keep;
  logic          m_last;
  logic          m_ready = 1'b1;
  logic          tile_done;
  logic [15:0]   beat_count;

  int checks = 0;
  int errors = 0;

  result_packer #(.W(W), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .tile_done  (tile_done),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data got %h exp 00000000", m_data); end
    checks++; if (m_keep !== 4'h0) begin errors++; $display("FAIL reset_m_keep got %h exp 0", m_keep); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
    checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL reset_tile_done got %b exp 0", tile_done); end
    checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL reset_beat_count got %0d exp 0", beat_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready elem %0d got %b exp 1", i, in_ready); end
      step();
      if (i == 4) begin
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h04030201 || m_keep !== 4'hF || m_last !== 1'b0) begin
          errors++; $display("FAIL stream_beat0 got v=%b d=%h k=%h l=%b exp v=1 d=04030201 k=f l=0", m_valid, m_data, m_keep, m_last);
        end
      end
      if (i == 5) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_gap got %b exp 0", m_valid); end
      end
      if (i == 8) begin
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h08070605 || m_keep !== 4'hF || m_last !== 1'b0) begin
          errors++; $display("FAIL stream_beat1 got v=%b d=%h k=%h l=%b exp v=1 d=08070605 k=f l=0", m_valid, m_data, m_keep, m_last);
        end
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %b exp 0", m_valid); end
    checks++; if (beat_count !== (STATS ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL stream_beat_count got %0d exp %0d", beat_count, STATS ? 2 : 0);
    end
  endtask

  task automatic test_partial_flush();
    in_valid = 1'b1; in_data = 8'hAA; step();
    in_data = 8'hBB; step();
    in_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h0000BBAA || m_keep !== 4'h3 || m_last !== 1'b1) begin
      errors++; $display("FAIL partial_beat got v=%b d=%h k=%h l=%b exp v=1 d=0000bbaa k=3 l=1", m_valid, m_data, m_keep, m_last);
    end
    checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL partial_tile_done_early got %b exp 0", tile_done); end
    step();
    checks++; if (tile_done !== 1'b1) begin errors++; $display("FAIL partial_tile_done got %b exp 1", tile_done); end
    step();
    checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL partial_tile_done_pulse got %b exp 0", tile_done); end
  endtask

  task automatic test_flush_coincident();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC1 + i);
      flush    = (i == 3);
      step();
    end
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'hC4C3C2C1 || m_keep !== 4'hF || m_last !== 1'b1) begin
      errors++; $display("FAIL coinc_beat got v=%b d=%h k=%h l=%b exp v=1 d=c4c3c2c1 k=f l=1", m_valid, m_data, m_keep, m_last);
    end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL coinc_no_empty got %b exp 0", m_valid); end
    checks++; if (tile_done !== 1'b1) begin errors++; $display("FAIL coinc_tile_done got %b exp 1", tile_done); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL coinc_no_empty2 got %b exp 0", m_valid); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h21 + i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready elem %0d got %b exp 1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_lanes_full_ready got %b exp 0", in_ready); end
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_flush_pending_ready got %b exp 0", in_ready); end
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h24232221 || m_keep !== 4'hF || m_last !== 1'b0) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h k=%h l=%b exp v=1 d=24232221 k=f l=0", m_valid, m_data, m_keep, m_last);
    end
    flush = 1'b1; step(); flush = 1'b0;
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h24232221 || m_keep !== 4'hF || m_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold2 got v=%b d=%h k=%h l=%b r=%b exp v=1 d=24232221 k=f l=0 r=0", m_valid, m_data, m_keep, m_last, in_ready);
    end
    m_ready = 1'b1; step();
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h00272625 || m_keep !== 4'h7 || m_last !== 1'b1) begin
      errors++; $display("FAIL bp_flush_beat got v=%b d=%h k=%h l=%b exp v=1 d=00272625 k=7 l=1", m_valid, m_data, m_keep, m_last);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_restored got %b exp 1", in_ready); end
    step();
    checks++; if (m_valid !== 1'b0 || tile_done !== 1'b1) begin
      errors++; $display("FAIL bp_done got v=%b td=%b exp v=0 td=1", m_valid, tile_done);
    end
  endtask

  task automatic test_empty_flush();
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h0 || m_keep !== 4'h0 || m_last !== 1'b1) begin
      errors++; $display("FAIL empty_beat got v=%b d=%h k=%h l=%b exp v=1 d=00000000 k=0 l=1", m_valid, m_data, m_keep, m_last);
    end
    step();
    checks++; if (m_valid !== 1'b0 || tile_done !== 1'b1) begin
      errors++; $display("FAIL empty_done got v=%b td=%b exp v=0 td=1", m_valid, tile_done);
    end
  endtask

  task automatic test_reset_midtile();
    in_valid = 1'b1; in_data = 8'h55; step();
    in_data = 8'h66; step();
    in_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    checks++; if (m_valid !== 1'b0 || beat_count !== 16'd0) begin
      errors++; $display("FAIL midrst_clear got v=%b bc=%0d exp v=0 bc=0", m_valid, beat_count);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      step();
    end
    in_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h13121110 || m_keep !== 4'hF || m_last !== 1'b0) begin
      errors++; $display("FAIL midrst_beat got v=%b d=%h k=%h l=%b exp v=1 d=13121110 k=f l=0", m_valid, m_data, m_keep, m_last);
    end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_single_beat got %b exp 0", m_valid); end
    checks++; if (beat_count !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL midrst_beat_count got %0d exp %0d", beat_count, STATS ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_partial_flush();
    test_flush_coincident();
    test_backpressure();
    test_empty_flush();
    test_reset_midtile();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
